// File: rtl/enc32to5_rr.sv
// Registered 32-to-5 encoder with fixed or round-robin priority, zero and multi-hot flags.
// One pipeline stage; valid/ready on both sides, output register overwritten on same-cycle handshake.
module enc32to5_rr #(
  parameter logic [4:0] RST_PTR  = 5'd0,
  parameter logic [4:0] ZERO_IDX = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [31:0] in_vec,
  input  logic        rr_en,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [4:0]  out_idx,
  output logic        out_zero,
  output logic        out_multi,
  output logic [4:0]  out_ptr
);

  logic        out_vld_q;
  logic [4:0]  out_idx_q, out_idx_d;
  logic        out_zero_q, out_zero_d;
  logic        out_multi_q, out_multi_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        accept;
  logic [31:0] rot_vec;
  logic [4:0]  rr_idx, fx_idx;

  function automatic logic [4:0] lsb_idx(input logic [31:0] v);
    lsb_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lsb_idx = 5'(i);
    end
  endfunction

  assign in_rdy = !out_vld_q || out_rdy;
  assign accept = in_vld && in_rdy;

  // Rotating right by ptr turns the round-robin scan into a plain lowest-bit search.
  assign rot_vec = (in_vec >> ptr_q) | (in_vec << (6'd32 - {1'b0, ptr_q}));
  assign rr_idx  = ptr_q + lsb_idx(rot_vec);
  assign fx_idx  = lsb_idx(in_vec);

  always_comb begin
    out_zero_d  = ~|in_vec;
    out_multi_d = |(in_vec & (in_vec - 32'd1));
    out_idx_d   = rr_en ? rr_idx : fx_idx;
    if (out_zero_d) out_idx_d = ZERO_IDX;
    ptr_d = ptr_q;
    if (accept && rr_en && !out_zero_d) ptr_d = out_idx_d + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q   <= 1'b0;
      out_idx_q   <= ZERO_IDX;
      out_zero_q  <= 1'b0;
      out_multi_q <= 1'b0;
      ptr_q       <= RST_PTR;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        out_vld_q   <= 1'b1;
        out_idx_q   <= out_idx_d;
        out_zero_q  <= out_zero_d;
        out_multi_q <= out_multi_d;
      end else if (out_rdy) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign out_vld   = out_vld_q;
  assign out_idx   = out_idx_q;
  assign out_zero  = out_zero_q;
  assign out_multi = out_multi_q;
  assign out_ptr   = ptr_q;

endmodule

// File: tb/tb_enc32to5_rr.sv
// Bench for enc32to5_rr: directed steps plus randomized traffic against a scanning reference model.
module tb_enc32to5_rr;

  localparam logic [4:0] P_RST_PTR  = 5'd3;
  localparam logic [4:0] P_ZERO_IDX = 5'd17;

  logic        clk = 1'b0;
  logic        rst, in_vld, rr_en, out_rdy;
  logic [31:0] in_vec;
  logic        in_rdy, out_vld, out_zero, out_multi;
  logic [4:0]  out_idx, out_ptr;

  int checks = 0;
  int errors = 0;

  logic       m_vld, m_zero, m_multi;
  logic [4:0] m_idx, m_ptr;

  enc32to5_rr #(.RST_PTR(P_RST_PTR), .ZERO_IDX(P_ZERO_IDX)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_vec(in_vec),
    .rr_en(rr_en), .out_vld(out_vld), .out_rdy(out_rdy), .out_idx(out_idx),
    .out_zero(out_zero), .out_multi(out_multi), .out_ptr(out_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count bits, then walk indices start, start+1, ... modulo 32.
  task automatic ref_enc(input logic [31:0] v, input logic rr, input logic [4:0] p,
                         output logic [4:0] idx, output logic z, output logic m);
    int cnt = 0;
    int start;
    idx = P_ZERO_IDX;
    for (int i = 0; i < 32; i++) cnt += int'(v[i]);
    z = (cnt == 0);
    m = (cnt >= 2);
    start = rr ? int'(p) : 0;
    if (!z) begin
      for (int i = 0; i < 32; i++) begin
        int j;
        j = (start + i) % 32;
        if (v[j]) begin
          idx = 5'(j);
          break;
        end
      end
    end
  endtask

  task automatic tick();
    logic       acc, rz, rm;
    logic [4:0] ri;
    #2;
    chk("in_rdy", 32'(in_rdy), 32'(!m_vld || out_rdy));
    acc = in_vld && (!m_vld || out_rdy);
    if (rst) begin
      m_vld = 1'b0; m_idx = P_ZERO_IDX; m_zero = 1'b0; m_multi = 1'b0; m_ptr = P_RST_PTR;
    end else if (acc) begin
      ref_enc(in_vec, rr_en, m_ptr, ri, rz, rm);
      m_vld = 1'b1; m_idx = ri; m_zero = rz; m_multi = rm;
      if (rr_en && !rz) m_ptr = 5'((int'(ri) + 1) % 32);
    end else if (out_rdy) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_vld", 32'(out_vld), 32'(m_vld));
    chk("out_idx", 32'(out_idx), 32'(m_idx));
    chk("out_zero", 32'(out_zero), 32'(m_zero));
    chk("out_multi", 32'(out_multi), 32'(m_multi));
    chk("out_ptr", 32'(out_ptr), 32'(m_ptr));
  endtask

  initial begin
    logic [4:0] exp_idx [4];
    logic [4:0] exp_ptr [4];
    exp_idx = '{5'd0, 5'd4, 5'd31, 5'd0};
    exp_ptr = '{5'd1, 5'd5, 5'd0, 5'd1};

    rst = 1'b1; in_vld = 1'b0; rr_en = 1'b0; out_rdy = 1'b1; in_vec = 32'h0;
    m_vld = 1'b0; m_idx = P_ZERO_IDX; m_zero = 1'b0; m_multi = 1'b0; m_ptr = P_RST_PTR;
    @(posedge clk);
    #1;
    tick();
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_ptr", 32'(out_ptr), 32'(P_RST_PTR));
    chk("rst_idx", 32'(out_idx), 32'(P_ZERO_IDX));

    // One-hot sweep, fixed priority, continuous flow.
    rst = 1'b0; in_vld = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_vec = 32'd1 << i;
      tick();
      chk("sweep_idx", 32'(out_idx), i);
      chk("sweep_vld", 32'(out_vld), 32'd1);
    end

    in_vec = 32'h0;
    tick();
    chk("zero_flag", 32'(out_zero), 32'd1);
    chk("zero_idx", 32'(out_idx), 32'(P_ZERO_IDX));
    chk("zero_ptr", 32'(out_ptr), 32'(P_RST_PTR));

    // Bring ptr from 3 to 0 through the 31 -> 0 wrap.
    rr_en = 1'b1; in_vec = 32'h8000_0000;
    tick();
    chk("wrap_ptr", 32'(out_ptr), 32'd0);

    in_vec = 32'h8000_0011;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_idx", 32'(out_idx), 32'(exp_idx[k]));
      chk("rr_ptr", 32'(out_ptr), 32'(exp_ptr[k]));
      chk("rr_multi", 32'(out_multi), 32'd1);
    end

    // Backpressure: drain, accept one, hold for three cycles, then replace without a bubble.
    in_vld = 1'b0;
    tick();
    in_vld = 1'b1; out_rdy = 1'b0; in_vec = 32'h0000_0100;
    tick();
    chk("bp_first", 32'(out_idx), 32'd8);
    in_vec = 32'h0000_0002;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold", 32'(out_idx), 32'd8);
    end
    out_rdy = 1'b1;
    tick();
    chk("bp_replace", 32'(out_idx), 32'd1);
    chk("bp_vld", 32'(out_vld), 32'd1);

    rr_en = 1'b0; in_vec = 32'hF000_0000;
    tick();
    chk("fix_idx", 32'(out_idx), 32'd28);
    chk("fix_ptr", 32'(out_ptr), 32'd2);
    rr_en = 1'b1; in_vec = 32'h0000_0005;
    tick();
    chk("resume_idx", 32'(out_idx), 32'd2);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      in_vld = $urandom_range(0, 3) != 0;
      out_rdy = $urandom_range(0, 2) != 0;
      rr_en = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: in_vec = 32'h0;
        1: in_vec = 32'd1 << $urandom_range(0, 31);
        2: in_vec = $urandom & $urandom & $urandom;
        default: in_vec = $urandom;
      endcase
      tick();
    end

    // Reset while a result is stalled.
    rst = 1'b0; in_vld = 1'b1; out_rdy = 1'b0; in_vec = 32'h0000_0040;
    tick();
    tick();
    chk("stall_vld", 32'(out_vld), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_vld", 32'(out_vld), 32'd0);
    chk("mid_rst_ptr", 32'(out_ptr), 32'(P_RST_PTR));
    #2;
    chk("mid_rst_rdy", 32'(in_rdy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc32to5_rr.md
Name: enc32to5_rr

Overview:
- Registered 32-to-5 encoder with optional round-robin priority; it is the inverse of the team's 5-to-32 one-hot decoder.
- Converts a 32-bit request/one-hot vector into a 5-bit index, a zero flag and a multi-hot flag.
- Used on arbitration and writeback paths wherever a decoded select vector must be collapsed back into a register or slot number.
- Single pipeline stage with a valid/ready handshake on both sides.

Parameters:
- RST_PTR, 5'd0, round-robin pointer value after reset (0..31).
- ZERO_IDX, 5'd0, value driven on out_idx when the accepted vector is all zeros.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_vld  input  1  in_vec valid.
- in_rdy  output  1  block can accept in_vec this cycle.
- in_vec  input  32  request / one-hot vector; bit i means index i.
- rr_en  input  1  1 = round-robin priority from ptr; 0 = fixed priority, lowest index wins. Sampled on accept.
- out_vld  output  1  result valid.
- out_rdy  input  1  consumer accepts result.
- out_idx  output  5  encoded index.
- out_zero  output  1  accepted vector was all zeros.
- out_multi  output  1  accepted vector had more than one bit set.
- out_ptr  output  5  current round-robin pointer (debug/visibility).

Behaviour:
- Reset (rst=1 at clk edge): out_vld=0, out_idx=ZERO_IDX, out_zero=0, out_multi=0, ptr=RST_PTR. Reset has priority over everything and may occur mid-operation; a pending result is discarded.
- in_rdy = !out_vld || out_rdy (combinational). Accept = in_vld && in_rdy.
- Latency: on accept at edge N, results are visible after edge N with out_vld=1. Throughput is one vector per cycle when out_rdy is held high.
- Hold: while out_vld=1 and out_rdy=0, out_idx, out_zero and out_multi are stable and in_rdy=0.
- Simultaneous out handshake and new accept in the same cycle: the output register is overwritten with the new result and out_vld stays 1.
- Out handshake with no accept: out_vld goes to 0 next edge. Data outputs keep their last values.
- Fixed mode (rr_en=0): out_idx = lowest set bit of in_vec. ptr is unchanged.
- Round-robin mode (rr_en=1): out_idx = first set bit scanning ptr, ptr+1, …, 31, 0, …, ptr-1 (mod 32). On accept of a nonzero vector, ptr <= out_idx+1 mod 32, so index 31 wraps ptr to 0.
- Zero vector: out_zero=1, out_idx=ZERO_IDX, out_multi=0, ptr unchanged in both modes. out_vld is still asserted; the zero result is a valid transaction.
- out_multi: 1 iff popcount(in_vec) ≥ 2. It is independent of mode. For a true one-hot input, out_idx is exact and out_multi=0.
- Changing rr_en between transactions is legal; ptr is retained across mode changes.
- No accept occurs while in_vld=0; in_vec is don't-care then.
- No X may propagate to outputs from any 32-bit input value.

Test Plan:
- Reset then in_vec=32'h0000_0001..32'h8000_0000 one-hot sweep, rr_en=0, out_rdy=1 -> out_idx=0..31 one cycle after each accept, out_multi=0, out_zero=0, out_vld continuous.
- in_vec=32'h0 -> out_zero=1, out_idx=ZERO_IDX, out_multi=0, ptr unchanged.
- rr_en=1, ptr=0, in_vec=32'h8000_0011 repeated 4 times -> out_idx 0,4,31,0. ptr goes 1,5,0,1. out_multi=1 on each result.
- Backpressure: out_rdy=0 for 3 cycles with in_vld=1 -> in_rdy=0, output held, single result. Then out_rdy=1 with a new vector -> same-cycle replace and no bubble.
- rr_en=0, in_vec=32'hF000_0000 -> out_idx=28, ptr unchanged. Then rr_en=1 -> scan starts from the preserved ptr.
- rst asserted while out_vld=1 and out_rdy=0 -> next edge out_vld=0, ptr=RST_PTR, in_rdy=1.
